led_scan: RTL and testbench

- Display-side reader of the 64-entry, 4-bit LED frame RAM (index = {row[2:0], col[2:0]}). The draw/color/erase logic writes that RAM; this block reads it.
- Scans the 8x8 bicolor matrix one row at a time.
- Prefetches the next row into a line buffer while the current row is displayed.
- Drives active-low one-hot row selects and active-high red/green column lines, with 2-bit PWM brightness.

---
 rtl/led_scan_pkg.sv | 39 +++
 rtl/led_row_fetch.sv | 75 +++++++
 rtl/led_scan.sv | 150 +++++++++++++++
 tb/tb_led_scan.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared constants for the LED matrix scanner: pixel word layout, color codes,
// default timing, and the per-pixel PWM/color decode.
package led_scan_pkg;

  localparam logic [1:0] COLOR_OFF    = 2'd0;
  localparam logic [1:0] COLOR_RED    = 2'd1;
  localparam logic [1:0] COLOR_GREEN  = 2'd2;
  localparam logic [1:0] COLOR_YELLOW = 2'd3;

  localparam int COLOR_LSB  = 0;
  localparam int COLOR_MSB  = 1;
  localparam int BRIGHT_LSB = 2;
  localparam int BRIGHT_MSB = 3;

  localparam int ROW_DWELL_DEF    = 2000;
  localparam int BLANK_CYCLES_DEF = 16;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  // Returns {green, red}; a pixel is lit while pwm <= brightness (duty (b+1)/4).
  function automatic logic [1:0] pixel_drive(input logic [3:0] pix, input logic [1:0] pwm);
    logic [1:0] color;
    logic [1:0] bright;
    logic       red;
    logic       green;
    color  = pix[COLOR_MSB:COLOR_LSB];
    bright = pix[BRIGHT_MSB:BRIGHT_LSB];
    red    = (color == COLOR_RED)   || (color == COLOR_YELLOW);
    green  = (color == COLOR_GREEN) || (color == COLOR_YELLOW);
    if (pwm <= bright) begin
      pixel_drive = {green, red};
    end else begin
      pixel_drive = 2'b00;
    end
  endfunction

endpackage

// File: rtl/led_row_fetch.sv
// Row prefetch engine: reads the 8 pixels of one row from the synchronous frame
// RAM into the back line buffer. Comes out of reset already fetching row 0.
module led_row_fetch
  import led_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  row,
  output logic [5:0]  rd_addr,
  input  logic [3:0]  rd_data,
  output logic [31:0] back,
  output logic [2:0]  back_row,
  output logic        done
);

  logic        iss_q, iss_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic        cap_q, cap_d;
  logic [2:0]  cap_col_q, cap_col_d;
  logic [31:0] back_q, back_d;

  // Address sequencer plus one-cycle-delayed capture of the RAM read data.
  always_comb begin
    iss_d     = iss_q;
    col_d     = col_q;
    row_d     = row_q;
    back_d    = back_q;
    cap_d     = iss_q;
    cap_col_d = col_q;
    if (cap_q) begin
      back_d[{cap_col_q, 2'b00} +: 4] = rd_data;
    end else begin
      back_d = back_q;
    end
    if (start) begin
      iss_d = 1'b1;
      col_d = 3'd0;
      row_d = row;
    end else if (iss_q) begin
      if (col_q == 3'd7) begin
        iss_d = 1'b0;
      end else begin
        col_d = col_q + 3'd1;
      end
    end else begin
      iss_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q     <= 1'b1;
      col_q     <= 3'd0;
      row_q     <= 3'd0;
      cap_q     <= 1'b0;
      cap_col_q <= 3'd0;
      back_q    <= 32'd0;
    end else begin
      iss_q     <= iss_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cap_q     <= cap_d;
      cap_col_q <= cap_col_d;
      back_q    <= back_d;
    end
  end

  assign rd_addr  = {row_q, col_q};
  assign back     = back_q;
  assign back_row = row_q;
  assign done     = cap_q && (cap_col_q == 3'd7);

endmodule

// File: rtl/led_scan.sv
// 8x8 bicolor LED matrix scanner: blank/show row timing, front line buffer,
// 2-bit PWM and registered active-low row / active-high column drive.
module led_scan
  import led_scan_pkg::*;
#(
  parameter int ROW_DWELL    = ROW_DWELL_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [5:0] rd_addr,
  input  logic [3:0] rd_data,
  output logic [7:0] row_n,
  output logic [7:0] col_r,
  output logic [7:0] col_g,
  output logic [2:0] cur_row,
  output logic       frame_start
);

  localparam int CW = $clog2((ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES);
  localparam logic [CW-1:0] DWELL_LAST = CW'(ROW_DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    cur_row_q, cur_row_d;
  logic [31:0]   front_q, front_d;
  logic [1:0]    pwm_q, pwm_d;
  logic [7:0]    row_n_q, row_n_d;
  logic [7:0]    col_r_q, col_r_d;
  logic [7:0]    col_g_q, col_g_d;
  logic          frame_start_q, frame_start_d;

  logic          fetch_start_s;
  logic [2:0]    fetch_row_s;
  logic [31:0]   back_s;
  logic [2:0]    back_row_s;
  logic          fetch_done_s;

  led_row_fetch u_fetch (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (fetch_start_s),
    .row      (fetch_row_s),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .back     (back_s),
    .back_row (back_row_s),
    .done     (fetch_done_s)
  );

  // Display FSM; the next row's fetch is launched as the new row enters SHOW.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_row_d     = cur_row_q;
    front_d       = front_q;
    pwm_d         = pwm_q;
    fetch_start_s = 1'b0;
    fetch_row_s   = 3'd0;
    case (state_q)
      ST_INIT: begin
        if (fetch_done_s) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d       = ST_SHOW;
          cnt_d         = '0;
          front_d       = back_s;
          cur_row_d     = back_row_s;
          pwm_d         = 2'd0;
          fetch_start_s = 1'b1;
          fetch_row_s   = back_row_s + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHOW: begin
        pwm_d = pwm_q + 2'd1;
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Next-cycle output drive from the current state and front buffer.
  always_comb begin
    logic [1:0] drv;
    drv           = 2'b00;
    row_n_d       = 8'hFF;
    col_r_d       = 8'h00;
    col_g_d       = 8'h00;
    frame_start_d = (state_q == ST_SHOW) && (cnt_q == '0) && (cur_row_q == 3'd0);
    if ((state_q == ST_SHOW) && en) begin
      row_n_d = ~(8'd1 << cur_row_q);
      for (int c = 0; c < 8; c++) begin
        drv        = pixel_drive(front_q[c*4 +: 4], pwm_q);
        col_r_d[c] = drv[0];
        col_g_d[c] = drv[1];
      end
    end else begin
      row_n_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      cur_row_q     <= 3'd0;
      front_q       <= 32'd0;
      pwm_q         <= 2'd0;
      row_n_q       <= 8'hFF;
      col_r_q       <= 8'h00;
      col_g_q       <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_row_q     <= cur_row_d;
      front_q       <= front_d;
      pwm_q         <= pwm_d;
      row_n_q       <= row_n_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row_n       = row_n_q;
  assign col_r       = col_r_q;
  assign col_g       = col_g_q;
  assign cur_row     = cur_row_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_scan.sv
// Testbench for led_scan: cycle-accurate reference of scan timing and pixel
// decode, fed by a behavioural synchronous frame RAM.
`timescale 1ns/1ps
module tb_led_scan;
  localparam int RD  = 16;
  localparam int BC  = 2;
  localparam int PER = RD + BC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [5:0] rd_addr;
  logic [3:0] rd_data = 4'h0;
  logic [7:0] row_n, col_r, col_g;
  logic [2:0] cur_row;
  logic       frame_start;

  logic [3:0] mem [64];
  logic [3:0] snap [8][8];
  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  logic en_prev = 1'b1;
  logic rand_mode = 1'b0;
  int   cnt_g0, cnt_r1, cnt_c2, cnt_old9, cnt_new9, fs_last;

  typedef struct packed {
    logic [7:0] row_n; logic [7:0] r; logic [7:0] g; logic fs; logic [5:0] addr; logic [2:0] cur;
  } obs_t;
  typedef struct { int t; logic [7:0] row_n; logic fs; logic [5:0] addr; logic chk_addr; } vec_t;

  led_scan #(.ROW_DWELL(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .row_n(row_n), .col_r(col_r), .col_g(col_g), .cur_row(cur_row), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  // Fetches start at cycle 0 (row 0) and at the first SHOW cycle of each row (next row).
  function automatic logic [5:0] exp_addr(input int tt);
    int u;
    if (tt < 8) return 6'(tt);
    if (tt < 11) return 6'd7;
    u = tt - 11;
    return {3'((u / PER + 1) % 8), ((u % PER) < 8) ? 3'(u % PER) : 3'd7};
  endfunction

  function automatic obs_t model(input int tt, input logic en_p);
    obs_t o;
    int u, p, row;
    logic [3:0] w;
    o = '{row_n: 8'hFF, r: 8'h00, g: 8'h00, fs: 1'b0, addr: exp_addr(tt), cur: 3'd0};
    if (tt >= 11) o.cur = 3'(((tt - 11) / PER) % 8);
    if (tt >= 12) begin
      u = tt - 12; p = u % PER; row = (u / PER) % 8;
      if (p < RD) begin
        o.fs = (p == 0) && (row == 0);
        if (en_p) begin
          o.row_n = ~(8'd1 << row);
          for (int c = 0; c < 8; c++) begin
            w = snap[row][c];
            if ((p % 4) <= int'(w[3:2])) begin
              o.r[c] = w[0];
              o.g[c] = w[1];
            end
          end
        end
      end
    end
    return o;
  endfunction

  task automatic sample();
    obs_t a, e;
    int r;
    r = -1;
    if (t == 0) r = 0;
    else if (t >= 11 && ((t - 11) % PER) == 0) r = ((t - 11) / PER + 1) % 8;
    if (r >= 0) for (int c = 0; c < 8; c++) snap[r][c] = mem[r*8 + c];
    e = model(t, en_prev);
    a = {row_n, col_r, col_g, frame_start, rd_addr, cur_row};
    chk("model", 40'(a), 40'(e));
    if (frame_start) begin
      if (fs_last >= 0) chk("fs_period", 40'(t - fs_last), 40'(144));
      fs_last = t;
    end
    if (t >= 12 && t <= 27) begin
      cnt_g0 += int'(col_g[0]); cnt_r1 += int'(col_r[1]); cnt_c2 += int'(col_r[2] | col_g[2]);
    end
    if (t >= 30 && t <= 45) cnt_old9 += int'(col_r[1] | col_g[1]);
    if (t >= 174 && t <= 189) cnt_new9 += int'(col_r[1] & col_g[1]);
    if (rand_mode) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if (t >= 11 && ((t - 11) % PER) >= 9 && $urandom_range(0, 2) == 0)
        mem[$urandom_range(0, 63)] = 4'($urandom);
    end
  endtask

  task automatic next();
    en_prev = en;
    @(negedge clk);
    t++;
    sample();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t = 0; fs_last = -1; en_prev = en;
    cnt_g0 = 0; cnt_r1 = 0; cnt_c2 = 0; cnt_old9 = 0; cnt_new9 = 0;
    #1 sample();
  endtask

  task automatic run_table();
    vec_t tab [8];
    tab[0] = '{0,  8'hFF, 1'b0, 6'd0, 1'b1};
    tab[1] = '{1,  8'hFF, 1'b0, 6'd1, 1'b1};
    tab[2] = '{5,  8'hFF, 1'b0, 6'd5, 1'b1};
    tab[3] = '{7,  8'hFF, 1'b0, 6'd7, 1'b1};
    tab[4] = '{10, 8'hFF, 1'b0, 6'd7, 1'b1};
    tab[5] = '{11, 8'hFF, 1'b0, 6'd0, 1'b0};
    tab[6] = '{12, 8'hFE, 1'b1, 6'd0, 1'b0};
    tab[7] = '{13, 8'hFE, 1'b0, 6'd0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      while (t < tab[i].t) next();
      chk("tab_row_n", 40'(row_n), 40'(tab[i].row_n));
      chk("tab_frame_start", 40'(frame_start), 40'(tab[i].fs));
      if (tab[i].chk_addr) chk("tab_rd_addr", 40'(rd_addr), 40'(tab[i].addr));
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, 40'({row_n, col_r, col_g, frame_start, rd_addr, cur_row}),
        40'({8'hFF, 8'h00, 8'h00, 1'b0, 6'd0, 3'd0}));
  endtask

  initial begin
    int tgt;
    for (int i = 0; i < 64; i++) mem[i] = 4'($urandom);
    mem[0] = 4'hE;  // green, brightness 3
    mem[1] = 4'h1;  // red, brightness 0
    mem[2] = 4'hC;  // color off at full brightness
    mem[9] = 4'h0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset_state");

    release_reset();
    run_table();
    while (t < 28) next();
    chk("row0_green_b3", 40'(cnt_g0), 40'(16));
    chk("row0_red_b0", 40'(cnt_r1), 40'(4));
    chk("row0_col2_off", 40'(cnt_c2), 40'(0));

    while (t < 40) next();
    mem[9] = 4'hF;  // row 1 is on display now; must not change until re-fetched
    while (t < 46) next();
    chk("row1_unchanged", 40'(cnt_old9), 40'(0));

    while (t < 52) next();
    en = 1'b0;
    next();
    chk("en_drop_row_n", 40'(row_n), 40'(8'hFF));
    chk("en_drop_cols", 40'({col_r, col_g}), 40'(16'h0000));
    repeat (4) next();
    en = 1'b1;
    repeat (2) next();
    chk("en_resume_row_n", 40'(row_n), 40'(8'hFB));
    chk("en_resume_cur_row", 40'(cur_row), 40'(3'd2));

    while (t < 119) next();
    chk("row7_fetch_first", 40'(rd_addr), 40'(6'd56));
    while (t < 126) next();
    chk("row7_fetch_last", 40'(rd_addr), 40'(6'd63));
    while (t < 137) next();
    chk("wrap_fetch_row0", 40'(rd_addr), 40'(6'd0));
    while (t < 190) next();
    chk("row1_new_frame", 40'(cnt_new9), 40'(16));

    rand_mode = 1'b1;
    while (t < 700) next();
    rand_mode = 1'b0;
    en = 1'b1;

    tgt = 50;
    while (tgt <= t + 2) tgt += 144;
    while (t < tgt) next();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset_mid_fetch");
    repeat (2) @(posedge clk);
    release_reset();
    run_table();
    while (t < 200) next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
